// File: rtl/mem_pkg.sv
// Shared types and default constants for the wait-state memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 16;
  localparam int DEF_WAIT_CYCLES = 1;

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, combinational read, no reset.
module mem_array #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Request/response memory slave with WAIT_CYCLES wait states per access.
// Optional preload port enabled by defining MEM_RESPONDER_LOAD_EN.
//
// state  | meaning
// S_IDLE | ready for a request (or a preload write)
// S_WAIT | counting wait states for the captured request
// S_RESP | response held until rsp_ready
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
`ifdef MEM_RESPONDER_LOAD_EN
  input  logic              load_we,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_wdata,
`endif
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_we
);

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state, state_nxt;
  logic [3:0]        cnt, cnt_nxt;
  logic              cap_we, cap_we_nxt;
  logic [ADDR_W-1:0] cap_addr, cap_addr_nxt;
  logic [DATA_W-1:0] cap_wdata, cap_wdata_nxt;
  logic [DATA_W-1:0] rsp_rdata_nxt;
  logic              rsp_we_nxt;
  logic              accept;
  logic              load_go;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

`ifdef MEM_RESPONDER_LOAD_EN
  assign load_go   = load_we && (state == S_IDLE);
  assign req_ready = (state == S_IDLE) && !load_we;
`else
  assign load_go   = 1'b0;
  assign req_ready = (state == S_IDLE);
`endif

  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == S_RESP);

  // Memory port mux kept apart from the FSM so the read path has no feedback.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = cap_addr;
    mem_wdata = cap_wdata;
    if (state == S_IDLE) begin
      if (load_go) begin
`ifdef MEM_RESPONDER_LOAD_EN
        mem_we    = 1'b1;
        mem_addr  = load_addr;
        mem_wdata = load_wdata;
`endif
      end else begin
        mem_addr  = req_addr;
        mem_wdata = req_wdata;
        mem_we    = accept && req_we && (WAIT_CYCLES == 0);
      end
    end else if (state == S_WAIT) begin
      mem_we = cap_we && (cnt == 4'd0);
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    cap_we_nxt    = cap_we;
    cap_addr_nxt  = cap_addr;
    cap_wdata_nxt = cap_wdata;
    rsp_rdata_nxt = rsp_rdata;
    rsp_we_nxt    = rsp_we;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cap_we_nxt    = req_we;
          cap_addr_nxt  = req_addr;
          cap_wdata_nxt = req_wdata;
          if (WAIT_CYCLES == 0) begin
            state_nxt     = S_RESP;
            rsp_we_nxt    = req_we;
            rsp_rdata_nxt = req_we ? '0 : mem_rdata;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = WAIT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt     = S_RESP;
          rsp_we_nxt    = cap_we;
          rsp_rdata_nxt = cap_we ? '0 : mem_rdata;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      cap_we    <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rsp_rdata <= '0;
      rsp_we    <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      cap_we    <= cap_we_nxt;
      cap_addr  <= cap_addr_nxt;
      cap_wdata <= cap_wdata_nxt;
      rsp_rdata <= rsp_rdata_nxt;
      rsp_we    <= rsp_we_nxt;
    end
  end

  // A reset edge must never commit an in-flight write.
  mem_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we && rst_n),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench: three responders with WAIT_CYCLES 1, 0 and 3 side by side.
module tb_mem_responder;

  typedef struct {
    logic        we;
    logic [15:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n     [3];
  logic        req_valid [3];
  logic        req_we    [3];
  logic [7:0]  req_addr  [3];
  logic [15:0] req_wdata [3];
  logic        req_ready [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [15:0] rsp_rdata [3];
  logic        rsp_we    [3];
  logic        load_we   [3];
  logic [7:0]  load_addr [3];
  logic [15:0] load_wdata[3];

  logic [15:0] model [3][256];
  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  function automatic int wc(input int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : 3;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mem_responder #(
      .ADDR_W(8), .DATA_W(16),
      .WAIT_CYCLES((g == 0) ? 1 : (g == 1) ? 0 : 3)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .req_valid (req_valid[g]),
      .req_we    (req_we[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .req_ready (req_ready[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
`ifdef MEM_RESPONDER_LOAD_EN
      .load_we   (load_we[g]),
      .load_addr (load_addr[g]),
      .load_wdata(load_wdata[g]),
`endif
      .rsp_rdata (rsp_rdata[g]),
      .rsp_we    (rsp_we[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One full transaction. After accept the req_* inputs are scrambled (and
  // req_valid optionally kept high) to show the captured values are used.
  task automatic transact(input int i, input logic we, input logic [7:0] addr,
                          input logic [15:0] wdata, input int hold, input bit keep_valid);
    exp_t e;
    exp_t got_e;
    int   lat;
    @(negedge clk);
    check($sformatf("ready_idle%0d", i), 32'(req_ready[i]), 32'd1);
    req_valid[i] = 1'b1;
    req_we[i]    = we;
    req_addr[i]  = addr;
    req_wdata[i] = wdata;
    @(negedge clk);
    e.we    = we;
    e.rdata = we ? 16'h0 : model[i][addr];
    if (we) model[i][addr] = wdata;
    sb.push_back(e);
    req_valid[i] = keep_valid;
    req_we[i]    = ~we;
    req_addr[i]  = ~addr;
    req_wdata[i] = ~wdata;
    lat = 1;
    while (!rsp_valid[i] && lat < 40) begin
      check($sformatf("ready_busy%0d", i), 32'(req_ready[i]), 32'd0);
      @(negedge clk);
      lat++;
    end
    check($sformatf("latency%0d", i), 32'(lat), 32'(wc(i) + 1));
    if (sb.size() == 0) begin
      check("sb_empty", 32'd1, 32'd0);
    end else begin
      got_e = sb.pop_front();
      check($sformatf("rsp_we%0d", i), 32'(rsp_we[i]), 32'(got_e.we));
      check($sformatf("rsp_rdata%0d", i), 32'(rsp_rdata[i]), 32'(got_e.rdata));
      for (int h = 0; h < hold; h++) begin
        @(negedge clk);
        check($sformatf("hold_valid%0d", i), 32'(rsp_valid[i]), 32'd1);
        check($sformatf("hold_rdata%0d", i), 32'(rsp_rdata[i]), 32'(got_e.rdata));
        check($sformatf("hold_ready%0d", i), 32'(req_ready[i]), 32'd0);
      end
    end
    check($sformatf("ready_before_hs%0d", i), 32'(req_ready[i]), 32'd0);
    rsp_ready[i] = 1'b1;
    @(negedge clk);
    rsp_ready[i] = 1'b0;
    req_valid[i] = 1'b0;
    check($sformatf("valid_after_hs%0d", i), 32'(rsp_valid[i]), 32'd0);
    check($sformatf("ready_after_hs%0d", i), 32'(req_ready[i]), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst_n[i] = 1'b0; req_valid[i] = 1'b0; req_we[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0; rsp_ready[i] = 1'b0;
      load_we[i] = 1'b0; load_addr[i] = '0; load_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst_ready%0d", i), 32'(req_ready[i]), 32'd1);
      check($sformatf("rst_valid%0d", i), 32'(rsp_valid[i]), 32'd0);
      check($sformatf("rst_rdata%0d", i), 32'(rsp_rdata[i]), 32'd0);
      check($sformatf("rst_we%0d", i), 32'(rsp_we[i]), 32'd0);
      rst_n[i] = 1'b1;
    end

    // WAIT_CYCLES=1: basic write then read-back
    transact(0, 1'b1, 8'h12, 16'hBEEF, 0, 1'b0);
    transact(0, 1'b0, 8'h12, 16'h0000, 0, 1'b0);

    // WAIT_CYCLES=0: boundary addresses, stalled response with req_valid held
    transact(1, 1'b1, 8'h00, 16'h0F0F, 0, 1'b0);
    transact(1, 1'b1, 8'hFF, 16'hF00D, 0, 1'b1);
    transact(1, 1'b0, 8'h00, 16'h0000, 5, 1'b1);
    transact(1, 1'b0, 8'hFF, 16'h0000, 2, 1'b0);

    // WAIT_CYCLES=3: reset during WAIT discards the write
    transact(2, 1'b1, 8'h05, 16'h1111, 0, 1'b0);
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 8'h05; req_wdata[2] = 16'h1234;
    @(negedge clk);
    req_valid[2] = 1'b0; req_addr[2] = 8'h00; req_wdata[2] = 16'h0000;
    @(negedge clk);
    rst_n[2] = 1'b0;
    @(negedge clk);
    rst_n[2] = 1'b1;
    check("rst_wait_ready", 32'(req_ready[2]), 32'd1);
    check("rst_wait_valid", 32'(rsp_valid[2]), 32'd0);
    repeat (6) @(negedge clk);
    check("rst_wait_norsp", 32'(rsp_valid[2]), 32'd0);
    transact(2, 1'b0, 8'h05, 16'h0000, 0, 1'b0);
    transact(2, 1'b1, 8'h80, 16'h5A5A, 1, 1'b1);
    transact(2, 1'b0, 8'h80, 16'h0000, 0, 1'b0);
    check("scramble_not_written", 32'(model[2][8'h7F] === 16'hA5A5), 32'd0);

`ifdef MEM_RESPONDER_LOAD_EN
    @(negedge clk);
    load_we[0] = 1'b1; load_addr[0] = 8'hFF; load_wdata[0] = 16'hA5A5;
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 8'h12;
    #1;
    check("load_ready", 32'(req_ready[0]), 32'd0);
    @(negedge clk);
    load_we[0] = 1'b0; req_valid[0] = 1'b0;
    model[0][8'hFF] = 16'hA5A5;
    check("load_noaccept", 32'(rsp_valid[0]), 32'd0);
    check("load_idle", 32'(req_ready[0]), 32'd1);
    transact(0, 1'b0, 8'hFF, 16'h0000, 0, 1'b0);
`endif

    // Random write/read-back pairs on every instance
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        logic [7:0]  a;
        logic [15:0] d;
        a = 8'($urandom_range(0, 255));
        d = 16'($urandom);
        transact(i, 1'b1, a, d, int'($urandom_range(0, 2)), 1'b0);
        transact(i, 1'b0, a, 16'h0000, 0, 1'($urandom_range(0, 1)));
      end
    end

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width.
REQ-002 SHALL have parameter DATA_W, default 16, data word width.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, legal range 0..15, added wait states per access.
REQ-004 SHALL have port clk  input  1  clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port req_valid  input  1  initiator presents a request.
REQ-007 SHALL have port req_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  ADDR_W  word address.
REQ-009 SHALL have port req_wdata  input  DATA_W  write data.
REQ-010 SHALL have port req_ready  output  1  responder can accept a request.
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator takes the response.
REQ-013 SHALL have port rsp_rdata  output  DATA_W  read data; 0 for write responses.
REQ-014 SHALL have port rsp_we  output  1  echo of the accepted req_we.

Function
REQ-015 SHALL implement FSM IDLE, WAIT, RESP, with storage of 2^ADDR_W words of DATA_W bits.
REQ-016 SHALL assert req_ready only in IDLE; a request is accepted on a clk edge with req_valid && req_ready.
REQ-017 SHALL capture req_we, req_addr and req_wdata on accept; later changes to the req_* inputs SHALL have no effect.
REQ-018 SHALL go IDLE->WAIT on accept when WAIT_CYCLES>0, load the wait counter with WAIT_CYCLES-1, and go WAIT->RESP when the counter is 0; otherwise the counter decrements.
REQ-019 SHALL go IDLE->RESP directly on accept when WAIT_CYCLES=0.
REQ-020 SHALL commit a write to storage, and sample read data into rsp_rdata, on the edge that enters RESP.
REQ-021 SHALL raise rsp_valid in the cycle after an accept at edge N, at edge N+1+WAIT_CYCLES.
REQ-022 SHALL hold rsp_valid, rsp_rdata and rsp_we stable in RESP until rsp_ready=1, then return to IDLE on that edge.
REQ-023 SHALL NOT accept a request on the same edge as a response handshake; minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-024 SHALL decode every address in the range, with no out-of-range case, and no address wrap beyond ADDR_W.

Reset
REQ-025 SHALL on rst_n=0 force state IDLE, wait counter 0, rsp_valid 0, rsp_rdata 0, rsp_we 0; req_ready SHALL then be 1.
REQ-026 SHALL discard an in-flight request on reset in WAIT, with no write committed; a reset in RESP drops the pending response.
REQ-027 SHALL NOT clear storage contents on reset.

Configuration
REQ-028 SHALL, with MEM_RESPONDER_LOAD_EN defined, add inputs load_we (1), load_addr (ADDR_W) and load_wdata (DATA_W) for program preload.
REQ-029 SHALL, with the macro defined, write load_wdata to load_addr on an edge with load_we=1 while in IDLE; load_we=1 SHALL force req_ready=0 in that cycle, giving the loader priority; load_we outside IDLE SHALL be ignored.
REQ-030 SHALL, without MEM_RESPONDER_LOAD_EN, have no load ports, and req_ready SHALL depend only on the state.

Structure
REQ-031 SHALL take the state enum (IDLE/WAIT/RESP encoding) and the default ADDR_W/DATA_W/WAIT_CYCLES constants from shared package mem_pkg.
REQ-032 SHALL instantiate one sub-module, mem_array: single-port storage with synchronous write and combinational read, used by both the request and load paths.

Verification
REQ-033 SHALL verify: WAIT_CYCLES=1, write addr 0x12 data 0xBEEF accepted at edge 0 -> rsp_valid at edge 2, rsp_we=1, rsp_rdata=0; then read 0x12 -> rsp_rdata=0xBEEF.
REQ-034 SHALL verify: WAIT_CYCLES=0, read accepted at edge N -> rsp_valid at edge N+1; req_ready=0 until the edge after the rsp_ready handshake.
REQ-035 SHALL verify: rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata stable throughout, and no new request accepted even with req_valid=1.
REQ-036 SHALL verify: write 0x1234 to addr 0x05 with rst_n pulsed low in WAIT (WAIT_CYCLES=3) -> no response, req_ready=1 after reset, read of 0x05 returns the prior value.
REQ-037 SHALL verify: with MEM_RESPONDER_LOAD_EN, load 0xA5A5 to addr 0xFF while req_valid=1 -> req_ready=0 that cycle; a subsequent read of 0xFF returns 0xA5A5.
REQ-038 SHALL verify: req_addr/req_wdata changed during WAIT -> the committed write uses the values captured at accept.
